clock_set_ctrl: RTL and testbench

Time-setting controller for the 50 MHz digital clock. It debounces the three raw push-buttons (Mode, Up, Down) and steps a mode state machine through RUN and three set modes. It drives one-cycle adjust pulses, with press-and-hold auto-repeat, into the hour and minute counters' Add/Subtract inputs and a clear into the seconds counter. It also gates the 1 Hz tick via Run_En and generates the blink enable for the selected display digits.

---
 rtl/clock_set_ctrl_if.sv | 26 ++
 rtl/clock_set_ctrl.sv | 158 +++++++++++++++
 tb/tb_clock_set_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/clock_set_ctrl_if.sv
// Key inputs and time-setting outputs of the clock_set_ctrl block.
interface clock_set_ctrl_if;
  logic       Key_Mode;
  logic       Key_Up;
  logic       Key_Down;
  logic       Hour_Add;
  logic       Hour_Subtract;
  logic       Minute_Add;
  logic       Minute_Subtract;
  logic       Second_Clear;
  logic       Run_En;
  logic [1:0] Mode;
  logic       Blink;

  modport master (
    output Key_Mode, Key_Up, Key_Down,
    input  Hour_Add, Hour_Subtract, Minute_Add, Minute_Subtract,
    input  Second_Clear, Run_En, Mode, Blink
  );

  modport slave (
    input  Key_Mode, Key_Up, Key_Down,
    output Hour_Add, Hour_Subtract, Minute_Add, Minute_Subtract,
    output Second_Clear, Run_En, Mode, Blink
  );
endinterface

// File: rtl/clock_set_ctrl.sv
// Time-setting controller: key debounce, RUN/SET mode FSM, adjust pulses with
// press-and-hold auto-repeat, and blink enable for the digits being set.
module csc_debounce #(
  parameter int CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_raw,
  output logic lvl,
  output logic fall
);
  localparam int CW = $clog2(CYCLES + 1);

  logic [1:0]    sync;
  logic          prev;
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync <= 2'b11;
      lvl  <= 1'b1;
      prev <= 1'b1;
      cnt  <= '0;
    end else begin
      sync <= {sync[0], key_raw};
      prev <= lvl;
      if (sync[1] == lvl) cnt <= '0;
      else if (cnt == CW'(CYCLES)) begin
        lvl <= sync[1];
        cnt <= '0;
      end else cnt <= cnt + CW'(1);
    end
  end

  assign fall = prev & ~lvl;
endmodule

module clock_set_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_DELAY    = 25_000_000,
  parameter int REPEAT_RATE     = 5_000_000,
  parameter int BLINK_HALF      = 12_500_000
) (
  input  logic Clk_50MHz,
  input  logic Reset_N,
  clock_set_ctrl_if.slave bus
);
  localparam int RW = $clog2(REPEAT_DELAY + 1);
  localparam int BW = $clog2(BLINK_HALF + 1);

  typedef enum logic [1:0] {RUN = 2'b00, SET_HOUR = 2'b01, SET_MIN = 2'b10, SET_SEC = 2'b11} mode_e;

  // key index: 0 = Mode, 1 = Up, 2 = Down
  logic [2:0] keys_raw, key_lvl, key_fall;
  assign keys_raw = {bus.Key_Down, bus.Key_Up, bus.Key_Mode};

  for (genvar k = 0; k < 3; k++) begin : g_db
    csc_debounce #(.CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (Clk_50MHz),
      .rst_n  (Reset_N),
      .key_raw(keys_raw[k]),
      .lvl    (key_lvl[k]),
      .fall   (key_fall[k])
    );
  end

  mode_e         state, state_n;
  logic [RW-1:0] rep_cnt;
  logic [BW-1:0] blink_cnt;
  logic          lock_up, lock_dn;
  logic          ha_q, hs_q, ma_q, ms_q, sc_q, run_q, blink_q;

  logic md_p, up_held, dn_held, up_go, dn_go, press, both, adj_mode, rep_act, rep_hit, fire;

  assign md_p     = key_fall[0];
  assign up_held  = ~key_lvl[1];
  assign dn_held  = ~key_lvl[2];
  assign both     = up_held & dn_held;
  assign up_go    = key_fall[1] & ~dn_held;
  assign dn_go    = key_fall[2] & ~up_held;
  assign press    = up_go | dn_go;
  assign adj_mode = (state == SET_HOUR) || (state == SET_MIN);
  // Only an unlocked key held on its own keeps the repeat counter running.
  assign rep_act  = adj_mode & ((up_held & ~lock_up & ~dn_held) | (dn_held & ~lock_dn & ~up_held));
  assign rep_hit  = rep_act & (rep_cnt == RW'(REPEAT_DELAY));
  assign fire     = ~md_p & (state != RUN) & (press | rep_hit);

  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) state <= RUN;
    else          state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (md_p) begin
      case (state)
        RUN:      state_n = SET_HOUR;
        SET_HOUR: state_n = SET_MIN;
        SET_MIN:  state_n = SET_SEC;
        default:  state_n = RUN;
      endcase
    end
  end

  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      rep_cnt <= '0;
      lock_up <= 1'b0;
      lock_dn <= 1'b0;
      ha_q    <= 1'b0;
      hs_q    <= 1'b0;
      ma_q    <= 1'b0;
      ms_q    <= 1'b0;
      sc_q    <= 1'b0;
      run_q   <= 1'b1;
    end else begin
      // A held key is locked out by a mode change or a chord until released.
      lock_up <= up_held & (lock_up | md_p | both);
      lock_dn <= dn_held & (lock_dn | md_p | both);

      if (!rep_act || md_p) rep_cnt <= '0;
      else if (press)       rep_cnt <= RW'(1);
      else if (rep_hit)     rep_cnt <= RW'(REPEAT_DELAY - REPEAT_RATE + 1);
      else                  rep_cnt <= rep_cnt + RW'(1);

      ha_q  <= fire & (state == SET_HOUR) & up_held;
      hs_q  <= fire & (state == SET_HOUR) & ~up_held;
      ma_q  <= fire & (state == SET_MIN)  & up_held;
      ms_q  <= fire & (state == SET_MIN)  & ~up_held;
      sc_q  <= fire & (state == SET_SEC);
      run_q <= (state_n == RUN);
    end
  end

  always_ff @(posedge Clk_50MHz or negedge Reset_N) begin
    if (!Reset_N) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (md_p || fire || state == RUN) begin
      blink_cnt <= '0;
      blink_q   <= 1'b1;
    end else if (blink_cnt == BW'(BLINK_HALF - 1)) begin
      blink_cnt <= '0;
      blink_q   <= ~blink_q;
    end else begin
      blink_cnt <= blink_cnt + BW'(1);
    end
  end

  assign bus.Hour_Add        = ha_q;
  assign bus.Hour_Subtract   = hs_q;
  assign bus.Minute_Add      = ma_q;
  assign bus.Minute_Subtract = ms_q;
  assign bus.Second_Clear    = sc_q;
  assign bus.Run_En          = run_q;
  assign bus.Mode            = state;
  assign bus.Blink           = blink_q;
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Scoreboard bench for clock_set_ctrl: expected pulses/mode changes are queued
// with their cycle when a key is driven and matched as the DUT emits them.
module tb_clock_set_ctrl;
  localparam int DB = 4, RD = 20, RR = 5, BH = 8;
  localparam int LAT = DB + 3;
  localparam int K_HA = 1, K_HS = 2, K_MA = 3, K_MS = 4, K_SC = 5, K_MODE = 8;

  typedef struct { int kind; int cyc; } ev_t;

  logic clk, rst_n;
  int   cyc, errors, checks, cur_mode;
  bit   mon_en;
  ev_t  exp_q[$];

  clock_set_ctrl_if bus();

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(DB), .REPEAT_DELAY(RD), .REPEAT_RATE(RR), .BLINK_HALF(BH)
  ) dut (
    .Clk_50MHz(clk),
    .Reset_N  (rst_n),
    .bus      (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic monitor();
    logic [1:0] pm;
    int kinds[2];
    int n, np;
    ev_t e;
    pm = 2'b00;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n = 0;
        if (bus.Mode !== pm) begin kinds[n] = K_MODE + int'(bus.Mode); n++; end
        np = int'(bus.Hour_Add) + int'(bus.Hour_Subtract) + int'(bus.Minute_Add)
           + int'(bus.Minute_Subtract) + int'(bus.Second_Clear);
        if (np > 0) begin
          checks++;
          if (np > 1) begin
            errors++;
            $display("FAIL onehot: %0d pulses at cycle %0d, required at most 1", np, cyc);
          end
          if      (bus.Hour_Add)        kinds[n] = K_HA;
          else if (bus.Hour_Subtract)   kinds[n] = K_HS;
          else if (bus.Minute_Add)      kinds[n] = K_MA;
          else if (bus.Minute_Subtract) kinds[n] = K_MS;
          else                          kinds[n] = K_SC;
          n++;
        end
        for (int i = 0; i < n; i++) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event: got kind %0d at cycle %0d, required none", kinds[i], cyc);
          end else begin
            e = exp_q.pop_front();
            if (e.kind !== kinds[i] || e.cyc !== cyc) begin
              errors++;
              $display("FAIL event: got kind %0d at cycle %0d, required kind %0d at cycle %0d",
                       kinds[i], cyc, e.kind, e.cyc);
            end
            if (e.kind >= K_MODE) begin
              checks++;
              if (bus.Run_En !== (e.kind == K_MODE)) begin
                errors++;
                $display("FAIL run_en: got %0b at cycle %0d, required %0b", bus.Run_En, cyc, e.kind == K_MODE);
              end
            end
          end
        end
      end
      pm = bus.Mode;
    end
  endtask

  task automatic set_key(input int which, input logic v);
    case (which)
      0:       bus.Key_Mode = v;
      1:       bus.Key_Up   = v;
      default: bus.Key_Down = v;
    endcase
  endtask

  // Drive one key low for 'hold' cycles; expect 'exp_kind' LAT edges later (<0: none).
  task automatic press(input int which, input int hold, input int exp_kind);
    set_key(which, 1'b0);
    if (exp_kind >= 0) exp_q.push_back('{exp_kind, cyc + 1 + LAT});
    repeat (hold) @(negedge clk);
    set_key(which, 1'b1);
    repeat (12) @(negedge clk);
  endtask

  task automatic goto_mode(input int m);
    int nm;
    while (cur_mode != m) begin
      nm = (cur_mode + 1) % 4;
      press(0, 10, K_MODE + nm);
      cur_mode = nm;
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_pending: %0d events outstanding, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_reset_values(input string name);
    checks++;
    if (bus.Mode !== 2'b00) begin errors++; $display("FAIL %s_mode: got %b, required 00", name, bus.Mode); end
    checks++;
    if (bus.Run_En !== 1'b1) begin errors++; $display("FAIL %s_run_en: got %b, required 1", name, bus.Run_En); end
    checks++;
    if (bus.Blink !== 1'b1) begin errors++; $display("FAIL %s_blink: got %b, required 1", name, bus.Blink); end
    checks++;
    if ({bus.Hour_Add, bus.Hour_Subtract, bus.Minute_Add, bus.Minute_Subtract, bus.Second_Clear} !== 5'b0) begin
      errors++;
      $display("FAIL %s_pulses: got %b, required 00000", name,
               {bus.Hour_Add, bus.Hour_Subtract, bus.Minute_Add, bus.Minute_Subtract, bus.Second_Clear});
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("reset");
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_values("post_reset");
    mon_en = 1'b1;
  endtask

  task automatic test_mode_cycle();
    int nm;
    for (int i = 0; i < 4; i++) begin
      nm = (cur_mode + 1) % 4;
      press(0, 10, K_MODE + nm);
      cur_mode = nm;
      checks++;
      if (bus.Mode !== 2'(nm)) begin errors++; $display("FAIL mode_cycle: got %b, required %0d", bus.Mode, nm); end
    end
    check_drained("mode_cycle");
  endtask

  task automatic test_repeat();
    int t;
    bus.Key_Up = 1'b0;
    t = cyc + 1;
    exp_q.push_back('{K_HA, t + LAT});
    exp_q.push_back('{K_HA, t + LAT + RD});
    exp_q.push_back('{K_HA, t + LAT + RD + RR});
    exp_q.push_back('{K_HA, t + LAT + RD + 2 * RR});
    // Released so the debounced level rises just before a fourth repeat would fire.
    repeat (35) @(negedge clk);
    bus.Key_Up = 1'b1;
    repeat (15) @(negedge clk);
    check_drained("repeat");
  endtask

  task automatic test_glitch();
    press(1, 3, -1);
    press(2, 10, K_MS);
    check_drained("glitch");
  endtask

  task automatic test_sec();
    int t, d;
    bus.Key_Up = 1'b0;
    t = cyc + 1;
    exp_q.push_back('{K_SC, t + LAT});
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      d = cyc - t;
      if (d == LAT || d == LAT + BH - 1 || d == LAT + 2 * BH) begin
        checks++;
        if (bus.Blink !== 1'b1) begin errors++; $display("FAIL sec_blink_on: got %b at +%0d, required 1", bus.Blink, d); end
      end
      if (d == LAT + BH || d == LAT + 3 * BH) begin
        checks++;
        if (bus.Blink !== 1'b0) begin errors++; $display("FAIL sec_blink_off: got %b at +%0d, required 0", bus.Blink, d); end
      end
    end
    bus.Key_Up = 1'b1;
    repeat (15) @(negedge clk);
    check_drained("sec");
  endtask

  task automatic test_both();
    for (int i = 0; i <= 80; i++) begin
      if (i == 0) begin
        bus.Key_Up = 1'b0;
        exp_q.push_back('{K_HA, cyc + 1 + LAT});
      end
      if (i == 10) bus.Key_Down = 1'b0;
      if (i == 40) bus.Key_Down = 1'b1;
      if (i == 80) bus.Key_Up = 1'b1;
      @(negedge clk);
    end
    repeat (12) @(negedge clk);
    press(1, 10, K_HA);
    check_drained("both");
  endtask

  task automatic test_reset_mid();
    int t;
    bus.Key_Up = 1'b0;
    t = cyc + 1;
    exp_q.push_back('{K_HA, t + LAT});
    exp_q.push_back('{K_HA, t + LAT + RD});
    repeat (30) @(negedge clk);
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_reset_values("reset_mid");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    cur_mode = 0;
    @(negedge clk);
    mon_en = 1'b1;
    repeat (30) @(negedge clk);
    bus.Key_Up = 1'b1;
    repeat (15) @(negedge clk);
    check_drained("reset_mid");
  endtask

  task automatic test_mode_lock();
    for (int i = 0; i <= 70; i++) begin
      if (i == 0) begin
        bus.Key_Up = 1'b0;
        exp_q.push_back('{K_HA, cyc + 1 + LAT});
      end
      if (i == 12) begin
        bus.Key_Mode = 1'b0;
        exp_q.push_back('{K_MODE + 2, cyc + 1 + LAT});
      end
      if (i == 22) bus.Key_Mode = 1'b1;
      if (i == 60) bus.Key_Up = 1'b1;
      @(negedge clk);
    end
    cur_mode = 2;
    repeat (12) @(negedge clk);
    press(1, 10, K_MA);
    check_drained("mode_lock");
  endtask

  initial begin
    rst_n = 1'b0;
    bus.Key_Mode = 1'b1;
    bus.Key_Up   = 1'b1;
    bus.Key_Down = 1'b1;
    cyc = 0; errors = 0; checks = 0; cur_mode = 0; mon_en = 1'b0;
    fork
      forever begin @(posedge clk); cyc++; end
      monitor();
    join_none
    @(negedge clk);
    test_reset();
    test_mode_cycle();
    goto_mode(1);
    test_repeat();
    goto_mode(2);
    test_glitch();
    goto_mode(3);
    test_sec();
    goto_mode(1);
    test_both();
    test_reset_mid();
    goto_mode(1);
    test_mode_lock();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
